// File: rtl/decode_queue_if.sv
// Handshake bundle between the fetch stage, the decode queue and the issue consumer.
// The master side drives fetch bundles, flush and out_ready; the slave side is the queue.
interface decode_queue_if #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_pc;
    logic [32*WIDTH-1:0]   in_inst;
    logic [WIDTH-1:0]      in_mask;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_pc;
    logic [31:0]           out_inst;
    logic [31:0]           out_uop;
    logic [CntW-1:0]       count;

    modport master (
        output flush, in_valid, in_pc, in_inst, in_mask, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_uop, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst, in_mask, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_uop, count
    );
endinterface

// File: rtl/decode_queue.sv
// RV32I decode queue: decodes up to WIDTH fetch slots per cycle, compacts the valid ones
// into a circular uop buffer and presents the oldest uop to the consumer.
module decode_queue #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decode_queue_if.slave bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    localparam logic [2:0] FuAlu = 3'd1;
    localparam logic [2:0] FuLsq = 3'd2;
    localparam logic [2:0] FuBra = 3'd3;

    localparam logic [3:0] ImmI = 4'd1;
    localparam logic [3:0] ImmS = 4'd2;
    localparam logic [3:0] ImmB = 4'd3;
    localparam logic [3:0] ImmU = 4'd4;
    localparam logic [3:0] ImmJ = 4'd5;

    localparam logic [3:0] AluAdd  = 4'd1;
    localparam logic [3:0] AluSub  = 4'd2;
    localparam logic [3:0] AluAnd  = 4'd3;
    localparam logic [3:0] AluOr   = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSll  = 4'd6;
    localparam logic [3:0] AluSrl  = 4'd7;
    localparam logic [3:0] AluSra  = 4'd8;
    localparam logic [3:0] AluSlt  = 4'd9;
    localparam logic [3:0] AluSltu = 4'd10;
    localparam logic [3:0] AluAp4  = 4'd11;
    localparam logic [3:0] AluOutb = 4'd12;

    localparam logic [6:0] OpReg    = 7'h33;
    localparam logic [6:0] OpImm    = 7'h13;
    localparam logic [6:0] OpLoad   = 7'h03;
    localparam logic [6:0] OpStore  = 7'h23;
    localparam logic [6:0] OpBranch = 7'h63;
    localparam logic [6:0] OpJal    = 7'h6f;
    localparam logic [6:0] OpJalr   = 7'h67;
    localparam logic [6:0] OpLui    = 7'h37;
    localparam logic [6:0] OpAuipc  = 7'h17;

    function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'd0:    op = alt ? AluSub : AluAdd;
            3'd1:    op = AluSll;
            3'd2:    op = AluSlt;
            3'd3:    op = AluSltu;
            3'd4:    op = AluXor;
            3'd5:    op = alt ? AluSra : AluSrl;
            3'd6:    op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] decode(input logic [31:0] inst);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ok;
        logic [2:0] fu;
        logic       r1, r2, rw, mrw, jl, jr;
        logic [3:0] imm, alu;
        logic [2:0] mrd, br;
        logic [1:0] mwr;
        op  = inst[6:0];
        f3  = inst[14:12];
        f7  = inst[31:25];
        ok  = 1'b0;
        fu  = 3'd0;
        r1  = 1'b0;
        r2  = 1'b0;
        rw  = 1'b0;
        mrw = 1'b0;
        jl  = 1'b0;
        jr  = 1'b0;
        imm = 4'd0;
        alu = 4'd0;
        mrd = 3'd0;
        br  = 3'd0;
        mwr = 2'd0;
        case (op)
            OpReg: begin
                ok  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
                fu  = FuAlu;
                r1  = 1'b1;
                r2  = 1'b1;
                rw  = 1'b1;
                alu = alu_op(f3, f7[5]);
            end
            OpImm: begin
                // Only the shift-immediates constrain funct7; imm[10] selects SRAI.
                if (f3 == 3'd1)      ok = (f7 == 7'h00);
                else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
                else                 ok = 1'b1;
                fu  = FuAlu;
                r1  = 1'b1;
                rw  = 1'b1;
                imm = ImmI;
                alu = alu_op(f3, (f3 == 3'd5) && f7[5]);
            end
            OpLoad: begin
                ok  = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                fu  = FuLsq;
                r1  = 1'b1;
                rw  = 1'b1;
                imm = ImmI;
                alu = AluAdd;
                mrd = f3[2] ? f3 : f3 + 3'd1;
            end
            OpStore: begin
                ok  = f3 < 3'd3;
                fu  = FuLsq;
                r1  = 1'b1;
                r2  = 1'b1;
                imm = ImmS;
                alu = AluAdd;
                mwr = f3[1:0] + 2'd1;
                mrw = 1'b1;
            end
            OpBranch: begin
                ok  = (f3 != 3'd2) && (f3 != 3'd3);
                fu  = FuBra;
                r1  = 1'b1;
                r2  = 1'b1;
                imm = ImmB;
                br  = f3[2] ? f3 - 3'd1 : f3 + 3'd1;
            end
            OpJal: begin
                ok  = 1'b1;
                fu  = FuBra;
                rw  = 1'b1;
                imm = ImmJ;
                alu = AluAp4;
                jl  = 1'b1;
            end
            OpJalr: begin
                ok  = (f3 == 3'd0);
                fu  = FuBra;
                r1  = 1'b1;
                rw  = 1'b1;
                imm = ImmI;
                alu = AluAp4;
                jr  = 1'b1;
            end
            OpLui: begin
                ok  = 1'b1;
                fu  = FuAlu;
                rw  = 1'b1;
                imm = ImmU;
                alu = AluOutb;
            end
            OpAuipc: begin
                ok  = 1'b1;
                fu  = FuAlu;
                rw  = 1'b1;
                imm = ImmU;
                alu = AluAdd;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) return 32'h0200_0000;
        return {6'd0, 1'b0, jr, jl, br, mrw, mwr, mrd, alu, imm, rw, r2, r1, fu};
    endfunction

    function automatic logic [PtrW-1:0] wrap(input logic [31:0] v);
        return PtrW'(v % DEPTH);
    endfunction

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;

    logic [31:0] pc_q   [DEPTH];
    logic [31:0] inst_q [DEPTH];
    logic [31:0] uop_q  [DEPTH];

    logic            push, pop;
    logic [CntW-1:0] mask_cnt, n_push;
    logic [PtrW-1:0] wr_idx   [WIDTH];
    logic [31:0]     slot_uop [WIDTH];

    assign bus.in_ready  = (count_q <= CntW'(DEPTH - WIDTH)) && !bus.flush;
    assign bus.out_valid = (count_q != '0);
    assign bus.count     = count_q;
    assign bus.out_pc    = pc_q[head_q];
    assign bus.out_inst  = inst_q[head_q];
    assign bus.out_uop   = uop_q[head_q];

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // Masked-off slots are squeezed out: each live slot lands after the live slots below it.
    always_comb begin
        mask_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_idx[i]   = wrap(32'(tail_q) + 32'(mask_cnt));
            slot_uop[i] = decode(bus.in_inst[32*i +: 32]);
            mask_cnt    = mask_cnt + CntW'(bus.in_mask[i]);
        end
        n_push = push ? mask_cnt : '0;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) head_d = wrap(32'(head_q) + 32'd1);
            tail_d  = wrap(32'(tail_q) + 32'(n_push));
            count_d = count_q + n_push - CntW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is qualified by count, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.in_mask[i]) begin
                    pc_q[wr_idx[i]]   <= bus.in_pc + 32'(4 * i);
                    inst_q[wr_idx[i]] <= bus.in_inst[32*i +: 32];
                    uop_q[wr_idx[i]]  <= slot_uop[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// Randomized bench for decode_queue: a queue-based reference model plus directed scenarios
// (push/pop, full, illegal, flush, mask and pointer wrap) with literal expectations.
module tb_decode_queue;
    localparam int unsigned WIDTH = 2;
    localparam int unsigned DEPTH = 4;

    localparam int FU_ALU = 1, FU_LSQ = 2, FU_BRA = 3;
    localparam int I_IMM = 1, S_IMM = 2, B_IMM = 3, U_IMM = 4, J_IMM = 5;
    localparam int ADD = 1, SUB = 2, AND_ = 3, OR_ = 4, XOR_ = 5, SLL = 6, SRL = 7, SRA = 8;
    localparam int SLT = 9, SLTU = 10, AP4 = 11, OUTB = 12;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] uop;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic run = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    decode_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    decode_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: classify by opcode, then look fields up from small tables.
    function automatic logic [31:0] ref_decode(input logic [31:0] x);
        int op, f3, f7;
        int fu, r1, r2, rw, imm, alu, mrd, mwr, mrw, br, jl, jr;
        bit ok;
        int alu_tab [8];
        int ld_tab  [8];
        int br_tab  [8];
        alu_tab = '{ADD, SLL, SLT, SLTU, XOR_, SRL, OR_, AND_};
        ld_tab  = '{1, 2, 3, 0, 4, 5, 0, 0};
        br_tab  = '{1, 2, 0, 0, 3, 4, 5, 6};
        op = int'(x[6:0]);
        f3 = int'(x[14:12]);
        f7 = int'(x[31:25]);
        {fu, r1, r2, rw, imm, alu, mrd, mwr, mrw, br, jl, jr} = '0;
        ok = 0;
        case (op)
            'h33: begin
                fu = FU_ALU; r1 = 1; r2 = 1; rw = 1;
                if (f7 == 0) begin ok = 1; alu = alu_tab[f3]; end
                else if (f7 == 'h20 && f3 == 0) begin ok = 1; alu = SUB; end
                else if (f7 == 'h20 && f3 == 5) begin ok = 1; alu = SRA; end
            end
            'h13: begin
                fu = FU_ALU; r1 = 1; rw = 1; imm = I_IMM; alu = alu_tab[f3];
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 'h20);
                    if (f7 == 'h20) alu = SRA;
                end else ok = 1;
            end
            'h03: begin
                fu = FU_LSQ; r1 = 1; rw = 1; imm = I_IMM; alu = ADD; mrd = ld_tab[f3];
                ok = (mrd != 0);
            end
            'h23: begin
                fu = FU_LSQ; r1 = 1; r2 = 1; imm = S_IMM; alu = ADD; mwr = f3 + 1; mrw = 1;
                ok = (f3 <= 2);
            end
            'h63: begin
                fu = FU_BRA; r1 = 1; r2 = 1; imm = B_IMM; br = br_tab[f3];
                ok = (br != 0);
            end
            'h6f: begin fu = FU_BRA; rw = 1; imm = J_IMM; alu = AP4; jl = 1; ok = 1; end
            'h67: begin fu = FU_BRA; r1 = 1; rw = 1; imm = I_IMM; alu = AP4; jr = 1; ok = (f3 == 0); end
            'h37: begin fu = FU_ALU; rw = 1; imm = U_IMM; alu = OUTB; ok = 1; end
            'h17: begin fu = FU_ALU; rw = 1; imm = U_IMM; alu = ADD; ok = 1; end
            default: ok = 0;
        endcase
        if (!ok) return 32'h0200_0000;
        return 32'(fu + (r1 << 3) + (r2 << 4) + (rw << 5) + (imm << 6) + (alu << 10) +
                   (mrd << 14) + (mwr << 17) + (mrw << 19) + (br << 20) + (jl << 23) + (jr << 24));
    endfunction

    // Model state advances on the edge using the inputs held across it.
    task automatic model_edge();
        int space;
        space = int'(DEPTH) - q.size();
        if (bus.flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && space >= int'(WIDTH)) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (bus.in_mask[i]) begin
                        ent_t e;
                        e.pc   = bus.in_pc + 32'(4 * i);
                        e.inst = bus.in_inst[32*i +: 32];
                        e.uop  = ref_decode(e.inst);
                        q.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic [63:0] insts,
                        input logic [1:0] m, input logic ordy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_inst   = insts;
        bus.in_mask   = m;
        bus.out_ready = ordy;
        bus.flush     = fl;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        x = $urandom();
        case ($urandom_range(0, 11))
            0: begin x[6:0] = 7'h33; x[31:25] = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00; end
            1: begin x[6:0] = 7'h13; x[31:25] = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00; end
            2: x[6:0] = 7'h03;
            3: x[6:0] = 7'h23;
            4: x[6:0] = 7'h63;
            5: x[6:0] = 7'h6f;
            6: x[6:0] = 7'h67;
            7: x[6:0] = 7'h37;
            8: x[6:0] = 7'h17;
            default: ;
        endcase
        return x;
    endfunction

    always @(negedge clk) begin
        if (run) begin
            chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            chk("count", 32'(bus.count), 32'(q.size()));
            chk("in_ready", 32'(bus.in_ready),
                32'(!bus.flush && (int'(DEPTH) - q.size() >= int'(WIDTH))));
            if (q.size() != 0) begin
                chk("out_pc", bus.out_pc, q[0].pc);
                chk("out_inst", bus.out_inst, q[0].inst);
                chk("out_uop", bus.out_uop, q[0].uop);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] two;
        bus.in_valid  = 0;
        bus.in_pc     = '0;
        bus.in_inst   = '0;
        bus.in_mask   = '0;
        bus.out_ready = 0;
        bus.flush     = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_count", 32'(bus.count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

        // addi x1,x0,5 then add x2,x1,x2
        step(1, 32'h100, {32'h0020_8133, 32'h0050_0093}, 2'b11, 0, 0);
        @(negedge clk);
        chk("push_pc", bus.out_pc, 32'h100);
        chk("push_fu", 32'(bus.out_uop[2:0]), 32'd1);
        chk("push_alu", 32'(bus.out_uop[13:10]), 32'd1);
        chk("push_imm", 32'(bus.out_uop[9:6]), 32'd1);
        chk("push_rs2", 32'(bus.out_uop[4]), 32'd0);
        chk("addi_uop", bus.out_uop, 32'h0000_0469);
        step(0, 0, 0, 2'b00, 1, 0);
        @(negedge clk);
        chk("pop_pc", bus.out_pc, 32'h104);
        chk("pop_rs2", 32'(bus.out_uop[4]), 32'd1);
        chk("pop_alu", 32'(bus.out_uop[13:10]), 32'd1);
        chk("add_uop", bus.out_uop, 32'h0000_0439);
        step(0, 0, 0, 2'b00, 1, 0);

        two = {32'h0050_0093, 32'h0050_0093};
        step(1, 32'h400, two, 2'b11, 0, 0);
        step(1, 32'h408, two, 2'b11, 0, 0);
        @(negedge clk);
        chk("full_count", 32'(bus.count), 32'd4);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        step(0, 0, 0, 2'b00, 1, 0);
        @(negedge clk);
        chk("full_pop1_ready", 32'(bus.in_ready), 32'd0);
        step(0, 0, 0, 2'b00, 1, 0);
        @(negedge clk);
        chk("full_pop2_ready", 32'(bus.in_ready), 32'd1);
        step(0, 0, 0, 2'b00, 1, 0);
        step(0, 0, 0, 2'b00, 1, 0);

        step(1, 32'h500, {32'h0000_0013, 32'hFFFF_FFFF}, 2'b01, 0, 0);
        @(negedge clk);
        chk("illegal_bit", 32'(bus.out_uop[25]), 32'd1);
        chk("illegal_fu", 32'(bus.out_uop[2:0]), 32'd0);
        chk("illegal_rw", 32'(bus.out_uop[5]), 32'd0);
        chk("illegal_uop", bus.out_uop, 32'h0200_0000);
        step(0, 0, 0, 2'b00, 1, 0);

        step(1, 32'h600, two, 2'b11, 0, 0);
        step(1, 32'h608, two, 2'b01, 0, 0);
        @(negedge clk);
        chk("preflush_count", 32'(bus.count), 32'd3);
        step(1, 32'h610, two, 2'b11, 1, 1);
        @(negedge clk);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_valid", 32'(bus.out_valid), 32'd0);

        step(1, 32'h200, two, 2'b10, 0, 0);
        @(negedge clk);
        chk("mask10_pc", bus.out_pc, 32'h204);
        chk("mask10_count", 32'(bus.count), 32'd1);
        for (int k = 0; k < 6; k++) begin
            step(1, 32'h300 + 32'(16 * k), two, 2'b01, 1, 0);
            @(negedge clk);
            chk("wrap_pc", bus.out_pc, 32'h300 + 32'(16 * k));
        end
        step(0, 0, 0, 2'b00, 1, 0);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                q.delete();
                #1;
                chk("midrun_reset_count", 32'(bus.count), 32'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
            step($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC,
                 {rand_inst(), rand_inst()}, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end
        step(0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
